// File: rtl/lane_serializer_40to10_pkg.sv
// lane_serializer_40to10_pkg: shared defaults, counter width and controller state encoding
package lane_serializer_40to10_pkg;
  localparam int LANES_DEF = 4;
  localparam int LANE_W_DEF = 10;
  localparam int WCNT_W = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;
endpackage

// File: rtl/lane_serializer_40to10_mux.sv
// lane_serializer_40to10_mux: picks one lane symbol out of a word given the output-order index
module lane_serializer_40to10_mux
  import lane_serializer_40to10_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CW = 2
) (
  input  logic [LANES*LANE_W-1:0] word,
  input  logic [CW-1:0]           idx,
  output logic [LANE_W-1:0]       sym
);
  logic [CW-1:0] phys;
  always_comb begin
    phys = MSB_FIRST ? CW'(LANES - 1) - idx : idx;
    sym = word[int'(phys)*LANE_W +: LANE_W];
  end
endmodule

// File: rtl/lane_serializer_40to10.sv
// lane_serializer_40to10: streams each wide input word out as LANES registered lane symbols
module lane_serializer_40to10
  import lane_serializer_40to10_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [LANES*LANE_W-1:0] s_data,
  input  logic                    abort,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LANE_W-1:0]       m_data,
  output logic [CW-1:0]           m_lane,
  output logic                    m_last,
  output logic [WCNT_W-1:0]       word_cnt
);
  state_t state;
  logic [LANES*LANE_W-1:0] hold;
  logic fire, done, accept;
  logic [CW-1:0] nxt;
  logic [LANE_W-1:0] sym;
  assign fire = m_valid & m_ready;
  assign done = fire & m_last;
  assign s_ready = !abort & ((state == ST_IDLE) | done);
  assign accept = s_valid & s_ready;
  assign nxt = m_lane + CW'(1);
  // a freshly accepted word bypasses the hold reg so lane 0 appears right after the accept edge
  lane_serializer_40to10_mux #(
    .LANES(LANES), .LANE_W(LANE_W), .MSB_FIRST(MSB_FIRST), .CW(CW)
  ) u_mux (
    .word(accept ? s_data : hold),
    .idx(accept ? '0 : nxt),
    .sym(sym)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      hold <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_lane <= '0;
      m_last <= 1'b0;
      word_cnt <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      m_valid <= 1'b0;
      m_lane <= '0;
      m_last <= 1'b0;
    end else begin
      if (done) word_cnt <= word_cnt + WCNT_W'(1);
      if (accept) begin
        state <= ST_SEND;
        hold <= s_data;
        m_valid <= 1'b1;
        m_data <= sym;
        m_lane <= '0;
        m_last <= 1'b0;
      end else if (done) begin
        state <= ST_IDLE;
        m_valid <= 1'b0;
        m_lane <= '0;
        m_last <= 1'b0;
      end else if (fire) begin
        m_data <= sym;
        m_lane <= nxt;
        m_last <= (nxt == CW'(LANES - 1));
      end
    end
  end
endmodule

// File: tb/tb_lane_serializer_40to10.sv
// tb_lane_serializer_40to10: queue-model checked bench driving LSB-first and MSB-first instances
`timescale 1ns/1ps
module tb_lane_serializer_40to10;
  localparam int L = 4;
  localparam int W = 10;
  logic clk = 0, rst = 1, s_valid = 0, abort = 0, m_ready = 1;
  logic [L*W-1:0] s_data = '0;
  logic s_ready0, m_valid0, m_last0, s_ready1, m_valid1, m_last1;
  logic [W-1:0] m_data0, m_data1;
  logic [1:0] m_lane0, m_lane1;
  logic [15:0] wcnt0, wcnt1;
  int total = 0, bad = 0;
  bit armed = 0;
  logic [L*W-1:0] q[$];
  int pos = 0;
  logic [15:0] mwc0 = 0, mwc1 = 0;
  localparam logic [L*W-1:0] W1 = {10'h3FF, 10'h200, 10'h0FF, 10'h001};
  localparam logic [L*W-1:0] W2A = {10'h00D, 10'h00C, 10'h00B, 10'h00A};
  localparam logic [L*W-1:0] W2B = {10'h1D1, 10'h1C1, 10'h1B1, 10'h1A1};
  localparam logic [L*W-1:0] W2C = {10'h2D2, 10'h2C2, 10'h2B2, 10'h2A2};
  localparam logic [L*W-1:0] W3 = {10'h111, 10'h222, 10'h333, 10'h044};
  localparam logic [L*W-1:0] W4 = {10'h3AA, 10'h155, 10'h2AA, 10'h0AA};
  localparam logic [L*W-1:0] W5 = {10'h004, 10'h003, 10'h002, 10'h3C1};
  localparam logic [L*W-1:0] W6 = {10'h3E0, 10'h3E1, 10'h3E2, 10'h3E3};

  always #5 clk = ~clk;

  lane_serializer_40to10 #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .abort(abort), .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
    .m_lane(m_lane0), .m_last(m_last0), .word_cnt(wcnt0)
  );
  lane_serializer_40to10 #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .abort(abort), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
    .m_lane(m_lane1), .m_last(m_last1), .word_cnt(wcnt1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: pending words as a queue plus the output position within the head word.
  always @(negedge clk) begin : model
    logic ev, er;
    logic [L*W-1:0] w;
    if (armed) begin
      ev = q.size() != 0;
      er = !abort && (!ev || (pos == L - 1 && m_ready));
      w = ev ? q[0] : '0;
      check("m_valid0", 64'(m_valid0), 64'(ev));
      check("m_valid1", 64'(m_valid1), 64'(ev));
      check("s_ready0", 64'(s_ready0), 64'(er));
      check("s_ready1", 64'(s_ready1), 64'(er));
      check("word_cnt0", 64'(wcnt0), 64'(mwc0));
      check("word_cnt1", 64'(wcnt1), 64'(mwc1));
      if (ev) begin
        check("m_data0", 64'(m_data0), 64'(w[pos*W +: W]));
        check("m_data1", 64'(m_data1), 64'(w[(L-1-pos)*W +: W]));
        check("m_lane0", 64'(m_lane0), 64'(pos));
        check("m_lane1", 64'(m_lane1), 64'(pos));
        check("m_last0", 64'(m_last0), 64'(pos == L - 1));
        check("m_last1", 64'(m_last1), 64'(pos == L - 1));
      end
      if (rst) begin
        q.delete();
        pos = 0;
        mwc0 = 0;
        mwc1 = 0;
      end else if (abort) begin
        q.delete();
        pos = 0;
      end else begin
        if (ev && m_ready) begin
          if (pos == L - 1) begin
            void'(q.pop_front());
            pos = 0;
            mwc0++;
            mwc1++;
          end else pos++;
        end
        if (s_valid && er) q.push_back(s_data);
      end
    end
  end

  task automatic send(input logic [L*W-1:0] w);
    bit ok = 0;
    s_valid = 1;
    s_data = w;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready0;
      @(posedge clk);
      #1;
    end
    check("send_accepted", 64'(ok), 64'(1));
    s_valid = 0;
  endtask

  task automatic drain;
    int n = 0;
    while (m_valid0 === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(m_valid0), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] e0[4], e1[4], cap0[4], cap1[4];
    logic [3:0] lst;
    e0 = '{10'h001, 10'h0FF, 10'h200, 10'h3FF};
    e1 = '{10'h3FF, 10'h200, 10'h0FF, 10'h001};
    repeat (2) @(posedge clk);
    armed = 1;
    #1 rst = 0;
    @(negedge clk);
    check("rst_valid", 64'(m_valid0), 64'(0));
    check("rst_data", 64'(m_data0), 64'(0));
    check("rst_lane", 64'(m_lane0), 64'(0));
    check("rst_last", 64'(m_last0), 64'(0));
    check("rst_wcnt", 64'(wcnt0), 64'(0));
    check("rst_ready", 64'(s_ready0), 64'(1));
    @(posedge clk);
    #1;
    // single word, both lane orders captured cycle by cycle
    send(W1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cap0[i] = m_data0;
      cap1[i] = m_data1;
      lst[i] = m_last0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t1_lsb_first", 64'(cap0[i]), 64'(e0[i]));
      check("t1_msb_first", 64'(cap1[i]), 64'(e1[i]));
    end
    check("t1_last", 64'(lst), 64'(4'b1000));
    check("t1_wcnt", 64'(wcnt0), 64'(1));
    check("t1_idle", 64'(m_valid0), 64'(0));
    // three words back to back
    send(W2A);
    send(W2B);
    send(W2C);
    drain();
    check("t2_wcnt", 64'(wcnt0), 64'(4));
    // stall on lane 1
    send(W3);
    @(posedge clk);
    #1;
    m_ready = 0;
    repeat (5) begin
      @(negedge clk);
      check("stall_data0", 64'(m_data0), 64'(10'h333));
      check("stall_data1", 64'(m_data1), 64'(10'h222));
      check("stall_lane", 64'(m_lane0), 64'(1));
      check("stall_ready", 64'(s_ready0), 64'(0));
      @(posedge clk);
      #1;
    end
    m_ready = 1;
    @(negedge clk);
    check("resume_lane", 64'(m_lane0), 64'(1));
    @(posedge clk);
    #1;
    drain();
    check("t3_wcnt", 64'(wcnt0), 64'(5));
    // abort during lane 2
    send(W4);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    abort = 1;
    @(negedge clk);
    check("abort_lane", 64'(m_lane0), 64'(2));
    check("abort_ready", 64'(s_ready0), 64'(0));
    @(posedge clk);
    #1;
    abort = 0;
    @(negedge clk);
    check("abort_valid", 64'(m_valid0), 64'(0));
    check("abort_wcnt", 64'(wcnt0), 64'(5));
    @(posedge clk);
    #1;
    // abort wins over an offered word while idle
    s_valid = 1;
    s_data = W5;
    abort = 1;
    @(negedge clk);
    check("idle_abort_ready", 64'(s_ready0), 64'(0));
    @(posedge clk);
    #1;
    abort = 0;
    s_valid = 0;
    @(negedge clk);
    check("idle_abort_valid", 64'(m_valid0), 64'(0));
    @(posedge clk);
    #1;
    send(W5);
    @(negedge clk);
    check("after_abort_lane", 64'(m_lane0), 64'(0));
    check("after_abort_data", 64'(m_data0), 64'(10'h3C1));
    @(posedge clk);
    #1;
    drain();
    check("t4_wcnt", 64'(wcnt0), 64'(6));
    // reset in the middle of a word
    send(W6);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("midrst_valid", 64'(m_valid0), 64'(0));
    check("midrst_data", 64'(m_data0), 64'(0));
    check("midrst_lane", 64'(m_lane0), 64'(0));
    check("midrst_last", 64'(m_last0), 64'(0));
    check("midrst_wcnt", 64'(wcnt0), 64'(0));
    check("midrst_ready", 64'(s_ready0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_stale", 64'(m_valid0), 64'(0));
    // counter wrap from 0xFFFF
    force dut0.word_cnt = 16'hFFFF;
    release dut0.word_cnt;
    mwc0 = 16'hFFFF;
    send(W1);
    drain();
    check("wrap_wcnt0", 64'(wcnt0), 64'(0));
    check("wrap_wcnt1", 64'(wcnt1), 64'(1));
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
